// File: rtl/expr_eval_ctrl.sv
// ============================================================================
//  Module      : expr_eval_ctrl
//  Description : Streaming ASCII expression recognizer/evaluator. Accepts one
//                character per handshake, checks "digit (op digit)* =" syntax,
//                evaluates with '*' binding tighter than '+' (modulo 2^WIDTH)
//                and presents one result per expression on a valid/ready port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module expr_eval_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             err,
    output logic             ovf
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,   // expecting the first digit
        S_OPND = 3'd1,   // a digit was just seen
        S_OPER = 3'd2,   // an operator was just seen
        S_ERR  = 3'd3,   // discarding until '='
        S_DONE = 3'd4    // result held for the consumer
    } state_t;

    localparam logic [7:0] c_CH_PLUS = 8'h2B;
    localparam logic [7:0] c_CH_STAR = 8'h2A;
    localparam logic [7:0] c_CH_EQ   = 8'h3D;
    localparam logic [7:0] c_CH_0    = 8'h30;
    localparam logic [7:0] c_CH_9    = 8'h39;

    state_t           r_state,    w_state_nxt;
    logic [WIDTH-1:0] r_sum,      w_sum_nxt;
    logic [WIDTH-1:0] r_prod,     w_prod_nxt;
    logic             r_pend_mul, w_pend_mul_nxt;
    logic             r_ovf_acc,  w_ovf_acc_nxt;
    logic [WIDTH-1:0] r_result,   w_result_nxt;
    logic             r_err,      w_err_nxt;
    logic             r_ovf,      w_ovf_nxt;

    logic             w_accept;
    logic             w_is_dig;
    logic             w_is_plus;
    logic             w_is_star;
    logic             w_is_eq;
    logic [3:0]       w_digit;
    logic [WIDTH:0]   w_add;
    logic [WIDTH+3:0] w_mul;

    // ASCII '0'..'9' carry their value in the low nibble
    assign w_is_dig  = (in >= c_CH_0) && (in <= c_CH_9);
    assign w_is_plus = (in == c_CH_PLUS);
    assign w_is_star = (in == c_CH_STAR);
    assign w_is_eq   = (in == c_CH_EQ);
    assign w_digit   = in[3:0];

    // Carry-out of the add and upper nibble of the multiply feed the sticky overflow
    assign w_add = {1'b0, r_sum} + {1'b0, r_prod};
    assign w_mul = {4'b0000, r_prod} * {{WIDTH{1'b0}}, w_digit};

    assign w_accept  = in_valid && (r_state != S_DONE);
    assign in_ready  = (r_state != S_DONE);
    assign res_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign err       = r_err;
    assign ovf       = r_ovf;

    // Next-state and datapath updates for each accepted character
    always_comb begin
        w_state_nxt    = r_state;
        w_sum_nxt      = r_sum;
        w_prod_nxt     = r_prod;
        w_pend_mul_nxt = r_pend_mul;
        w_ovf_acc_nxt  = r_ovf_acc;
        w_result_nxt   = r_result;
        w_err_nxt      = r_err;
        w_ovf_nxt      = r_ovf;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_is_dig) begin
                        w_state_nxt    = S_OPND;
                        w_sum_nxt      = '0;
                        w_prod_nxt     = {{(WIDTH-4){1'b0}}, w_digit};
                        w_ovf_acc_nxt  = 1'b0;
                        w_pend_mul_nxt = 1'b0;
                    end else if (w_is_eq) begin
                        w_state_nxt  = S_DONE;
                        w_result_nxt = '0;
                        w_err_nxt    = 1'b1;
                        w_ovf_nxt    = 1'b0;
                    end else begin
                        w_state_nxt = S_ERR;
                    end
                end
            end
            S_OPND: begin
                if (w_accept) begin
                    if (w_is_plus) begin
                        w_state_nxt    = S_OPER;
                        w_sum_nxt      = w_add[WIDTH-1:0];
                        w_ovf_acc_nxt  = r_ovf_acc | w_add[WIDTH];
                        w_pend_mul_nxt = 1'b0;
                    end else if (w_is_star) begin
                        w_state_nxt    = S_OPER;
                        w_pend_mul_nxt = 1'b1;
                    end else if (w_is_eq) begin
                        w_state_nxt  = S_DONE;
                        w_result_nxt = w_add[WIDTH-1:0];
                        w_err_nxt    = 1'b0;
                        w_ovf_nxt    = r_ovf_acc | w_add[WIDTH];
                    end else begin
                        // a second digit in a row (multi-digit number) or junk
                        w_state_nxt = S_ERR;
                    end
                end
            end
            S_OPER: begin
                if (w_accept) begin
                    if (w_is_dig) begin
                        w_state_nxt = S_OPND;
                        if (r_pend_mul) begin
                            w_prod_nxt    = w_mul[WIDTH-1:0];
                            w_ovf_acc_nxt = r_ovf_acc | (|w_mul[WIDTH+3:WIDTH]);
                        end else begin
                            w_prod_nxt = {{(WIDTH-4){1'b0}}, w_digit};
                        end
                    end else if (w_is_eq) begin
                        w_state_nxt  = S_DONE;
                        w_result_nxt = '0;
                        w_err_nxt    = 1'b1;
                        w_ovf_nxt    = 1'b0;
                    end else begin
                        w_state_nxt = S_ERR;
                    end
                end
            end
            S_ERR: begin
                if (w_accept && w_is_eq) begin
                    w_state_nxt  = S_DONE;
                    w_result_nxt = '0;
                    w_err_nxt    = 1'b1;
                    w_ovf_nxt    = 1'b0;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state    <= S_IDLE;
            r_sum      <= '0;
            r_prod     <= '0;
            r_pend_mul <= 1'b0;
            r_ovf_acc  <= 1'b0;
            r_result   <= '0;
            r_err      <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sum      <= w_sum_nxt;
            r_prod     <= w_prod_nxt;
            r_pend_mul <= w_pend_mul_nxt;
            r_ovf_acc  <= w_ovf_acc_nxt;
            r_result   <= w_result_nxt;
            r_err      <= w_err_nxt;
            r_ovf      <= w_ovf_nxt;
        end
    end

endmodule

`default_nettype wire
